// File: rtl/dsp_pipe_reg.sv
// rtl/dsp_pipe_reg.sv - valid-tagged DSP pipeline register with clock enable, scoped clear and occupancy count
module dsp_pipe_reg #(
    parameter int              WIDTH      = 18,
    parameter int              DEPTH      = 1,
    parameter int              CLEAR_MODE = 1,
    parameter logic [WIDTH-1:0] RST_VAL   = '0,
    localparam int             OCC_W      = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             sclr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    if (DEPTH == 0) begin : g_bypass
        // Pure wires: control inputs are intentionally ignored in bypass mode.
        logic unused_ctrl;
        assign unused_ctrl = &{1'b0, clk, rst_n, ce, sclr};
        assign out_data    = in_data;
        assign out_valid   = in_valid;
        assign occupancy   = '0;
    end else begin : g_pipe
        logic [WIDTH-1:0] data_q [DEPTH];
        logic [WIDTH-1:0] data_d [DEPTH];
        logic [DEPTH-1:0] valid_q;
        logic [DEPTH-1:0] valid_d;
        logic [OCC_W-1:0] occ_q;
        logic [OCC_W-1:0] occ_d;

        always_comb begin
            data_d  = data_q;
            valid_d = valid_q;
            occ_d   = occ_q;
            if (sclr) begin
                valid_d = '0;
                occ_d   = '0;
                if (CLEAR_MODE != 0) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        data_d[k] = RST_VAL;
                    end
                end
            end else if (ce) begin
                data_d[0]  = in_data;
                valid_d[0] = in_valid;
                for (int k = 1; k < DEPTH; k++) begin
                    data_d[k]  = data_q[k-1];
                    valid_d[k] = valid_q[k-1];
                end
                // Word entering and word leaving cancel; the count stays in 0..DEPTH.
                occ_d = occ_q + OCC_W'(in_valid) - OCC_W'(valid_q[DEPTH-1]);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < DEPTH; k++) begin
                    data_q[k] <= RST_VAL;
                end
                valid_q <= '0;
                occ_q   <= '0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
                occ_q   <= occ_d;
            end
        end

        assign out_data  = data_q[DEPTH-1];
        assign out_valid = valid_q[DEPTH-1];
        assign occupancy = occ_q;
    end

endmodule

// File: tb/tb_dsp_pipe_reg.sv
// tb/tb_dsp_pipe_reg.sv - randomized self-checking bench for dsp_pipe_reg against a queue-based delay-line model
module tb_dsp_pipe_reg;

    localparam int W = 16;
    localparam int N = 4;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
    } word_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         ce = 1'b0;
    logic         sclr = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;

    logic         ov [N];
    logic [W-1:0] od [N];
    logic [1:0]   occ3, occ2a, occ2b;
    logic [2:0]   occ4;
    logic         ov0;
    logic [W-1:0] od0;
    logic [0:0]   occ0;

    int           dep [N] = '{3, 2, 2, 4};
    int           cmode [N] = '{1, 0, 1, 0};
    logic [W-1:0] rval [N] = '{16'h0000, 16'h0000, 16'h0003, 16'hBEEF};
    word_t        pipe [N][$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dsp_pipe_reg #(.WIDTH(W), .DEPTH(3), .CLEAR_MODE(1), .RST_VAL(16'h0000)) u_d3 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .sclr(sclr), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov[0]), .out_data(od[0]), .occupancy(occ3));
    dsp_pipe_reg #(.WIDTH(W), .DEPTH(2), .CLEAR_MODE(0), .RST_VAL(16'h0000)) u_d2a (
        .clk(clk), .rst_n(rst_n), .ce(ce), .sclr(sclr), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov[1]), .out_data(od[1]), .occupancy(occ2a));
    dsp_pipe_reg #(.WIDTH(W), .DEPTH(2), .CLEAR_MODE(1), .RST_VAL(16'h0003)) u_d2b (
        .clk(clk), .rst_n(rst_n), .ce(ce), .sclr(sclr), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov[2]), .out_data(od[2]), .occupancy(occ2b));
    dsp_pipe_reg #(.WIDTH(W), .DEPTH(4), .CLEAR_MODE(0), .RST_VAL(16'hBEEF)) u_d4 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .sclr(sclr), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov[3]), .out_data(od[3]), .occupancy(occ4));
    dsp_pipe_reg #(.WIDTH(W), .DEPTH(0), .CLEAR_MODE(1), .RST_VAL(16'h0000)) u_d0 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .sclr(sclr), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov0), .out_data(od0), .occupancy(occ0));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_occ(input int i);
        case (i)
            0:       return 32'(occ3);
            1:       return 32'(occ2a);
            2:       return 32'(occ2b);
            default: return 32'(occ4);
        endcase
    endfunction

    function automatic int model_count(input int i);
        int c = 0;
        foreach (pipe[i][k]) c += int'(pipe[i][k].v);
        return c;
    endfunction

    task automatic model_reset();
        word_t w;
        for (int i = 0; i < N; i++) begin
            pipe[i].delete();
            w.v = 1'b0;
            w.d = rval[i];
            for (int k = 0; k < dep[i]; k++) pipe[i].push_back(w);
        end
    endtask

    task automatic model_edge();
        word_t w;
        for (int i = 0; i < N; i++) begin
            if (sclr) begin
                for (int k = 0; k < dep[i]; k++) begin
                    w = pipe[i][k];
                    w.v = 1'b0;
                    if (cmode[i] != 0) w.d = rval[i];
                    pipe[i][k] = w;
                end
            end else if (ce) begin
                w.v = in_valid;
                w.d = in_data;
                pipe[i].push_front(w);
                void'(pipe[i].pop_back());
            end
        end
    endtask

    task automatic compare_all();
        word_t last;
        for (int i = 0; i < N; i++) begin
            last = pipe[i][dep[i]-1];
            check($sformatf("d%0d_%0d out_valid", dep[i], i), 32'(ov[i]), 32'(last.v));
            check($sformatf("d%0d_%0d out_data", dep[i], i), 32'(od[i]), 32'(last.d));
            check($sformatf("d%0d_%0d occupancy", dep[i], i), dut_occ(i), 32'(model_count(i)));
        end
        check("d0 out_valid", 32'(ov0), 32'(in_valid));
        check("d0 out_data", 32'(od0), 32'(in_data));
        check("d0 occupancy", 32'(occ0), 32'd0);
    endtask

    // Inputs are stable across the rising edge; the model follows that edge, outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic c, input logic s, input logic v, input logic [W-1:0] d);
        ce = c;
        sclr = s;
        in_valid = v;
        in_data = d;
    endtask

    task automatic async_reset(input int cycles);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("reset d2 immediate out_data", 32'(od[2]), 32'h3);
        repeat (cycles) step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Simple stream 1..4 into all pipes.
        for (int n = 1; n <= 4; n++) begin
            drive(1'b1, 1'b0, 1'b1, W'(n));
            step();
            if (n == 1) check("d3 occ after first", 32'(occ3), 32'd1);
            if (n == 3) begin
                check("d3 first out_data", 32'(od[0]), 32'h1);
                check("d3 first out_valid", 32'(ov[0]), 32'h1);
                check("d3 occ full", 32'(occ3), 32'd3);
            end
            if (n == 4) check("d3 second out_data", 32'(od[0]), 32'h2);
        end

        drive(1'b1, 1'b0, 1'b1, 16'h0055);
        step();
        drive(1'b1, 1'b0, 1'b1, 16'h0066);
        step();
        drive(1'b0, 1'b0, 1'b1, 16'h0099);
        repeat (4) step();
        check("d2a held out_data", 32'(od[1]), 32'h55);

        // Clear while the clock enable is low.
        drive(1'b0, 1'b1, 1'b1, 16'h0099);
        step();
        check("d2a clear keeps data", 32'(od[1]), 32'h55);
        check("d2a clear out_valid", 32'(ov[1]), 32'h0);
        check("d2b clear loads rst_val", 32'(od[2]), 32'h3);
        check("d4 clear occupancy", 32'(occ4), 32'h0);

        // Alternating valid stream.
        for (int n = 0; n < 12; n++) begin
            drive(1'b1, 1'b0, 1'((n + 1) % 2), W'(16'h10 + (n % 4)));
            step();
        end
        check("d4 alternating occupancy", 32'(occ4), 32'd2);

        // Random traffic with a mid-stream reset.
        for (int n = 0; n < 600; n++) begin
            drive(1'(($urandom % 4) != 0), 1'(($urandom % 25) == 0), 1'($urandom), W'($urandom));
            step();
            if (n == 300) begin
                drive(1'b1, 1'b0, 1'b1, 16'h0007);
                async_reset(2);
            end
        end

        drive(1'b1, 1'b0, 1'b1, 16'h0007);
        step();
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        step();
        check("d2b refill out_data", 32'(od[2]), 32'h7);
        check("d2b refill out_valid", 32'(ov[2]), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
